// File: rtl/mul_share_arb.sv
// Shares one pipelined multiplier among NREQ requesters and routes each product back to its requester.
// Define MUL_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module mul_share_arb #(
    parameter int SIZE    = 4,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*SIZE-1:0]   req_a,
    input  logic [NREQ*SIZE-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [SIZE-1:0]        mul_a,
    output logic [SIZE-1:0]        mul_b,
    input  logic [2*SIZE-1:0]      mul_res,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [2*SIZE-1:0]      rsp_data,
    output logic                   busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(MUL_LAT + 1);

    logic            grantValid;
    logic [IDXW-1:0] grantIdx;
    logic            grantOk;
    logic            rspFire;
    logic [IDXW-1:0] rspIdx;

    logic [MUL_LAT-1:0] tagValid_q;
    logic [IDXW-1:0]    tagIdx_q [MUL_LAT];
    logic [CNTW-1:0]    inFlight_q, inFlight_d;

`ifdef MUL_ARB_RR_EN
    logic [IDXW-1:0] rrPtr_q, rrPtr_d;

    // Search upward from the pointer, wrapping at NREQ; first valid candidate wins.
    always_comb begin : rrSearch
        logic [IDXW:0] cand;
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rrPtr_q} + (IDXW+1)'(k);
            if (cand >= (IDXW+1)'(NREQ)) begin
                cand = cand - (IDXW+1)'(NREQ);
            end
            if (!grantValid && req_valid[cand[IDXW-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (grantOk) begin
            rrPtr_d = (grantIdx == IDXW'(NREQ - 1)) ? '0 : grantIdx + IDXW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end
`else
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grantValid = 1'b1;
                grantIdx   = IDXW'(i);
            end
        end
    end
`endif

    assign grantOk = grantValid & rst_n;

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (grantOk) begin
            req_ready[grantIdx] = 1'b1;
            mul_a               = req_a[grantIdx*SIZE +: SIZE];
            mul_b               = req_b[grantIdx*SIZE +: SIZE];
        end
    end

    // Tag pipe mirrors the multiplier latency so the tag exits alongside its product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagValid_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tagIdx_q[i] <= '0;
            end
        end else begin
            tagValid_q[0] <= grantOk;
            tagIdx_q[0]   <= grantIdx;
            for (int i = 1; i < MUL_LAT; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagIdx_q[i]   <= tagIdx_q[i-1];
            end
        end
    end

    assign rspFire = tagValid_q[MUL_LAT-1] & rst_n;
    assign rspIdx  = tagIdx_q[MUL_LAT-1];

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (rspFire) begin
            rsp_valid[rspIdx] = 1'b1;
            rsp_data          = mul_res;
        end
    end

    always_comb begin
        inFlight_d = inFlight_q;
        if (grantOk && !rspFire) begin
            inFlight_d = inFlight_q + CNTW'(1);
        end else if (!grantOk && rspFire) begin
            inFlight_d = inFlight_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inFlight_q <= '0;
        end else begin
            inFlight_q <= inFlight_d;
        end
    end

    // Busy counts this cycle's grant and drops as the last product is delivered.
    assign busy = rst_n & (inFlight_d != '0);

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: directed vector table, corner sequences and a randomized run
// against a queue-based reference model. Follows MUL_ARB_RR_EN like the design.
module tb_mul_share_arb;

    localparam int SIZE    = 4;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;
    localparam int W       = NREQ * SIZE;

    logic                clk;
    logic                rstN;
    logic [NREQ-1:0]     reqValid;
    logic [W-1:0]        reqA;
    logic [W-1:0]        reqB;
    logic [NREQ-1:0]     reqReady;
    logic [SIZE-1:0]     mulA;
    logic [SIZE-1:0]     mulB;
    logic [2*SIZE-1:0]   mulRes;
    logic [NREQ-1:0]     rspValid;
    logic [2*SIZE-1:0]   rspData;
    logic                busy;

    int testCount = 0;
    int failCount = 0;

    mul_share_arb #(.SIZE(SIZE), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .req_valid (reqValid),
        .req_a     (reqA),
        .req_b     (reqB),
        .req_ready (reqReady),
        .mul_a     (mulA),
        .mul_b     (mulB),
        .mul_res   (mulRes),
        .rsp_valid (rspValid),
        .rsp_data  (rspData),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared multiplier: product appears MUL_LAT edges after its operands.
    logic [2*SIZE-1:0] mulPipe [MUL_LAT];
    always @(posedge clk) begin
        mulPipe[0] <= mulA * mulB;
        for (int i = 1; i < MUL_LAT; i++) begin
            mulPipe[i] <= mulPipe[i-1];
        end
    end
    assign mulRes = mulPipe[MUL_LAT-1];

    typedef struct {
        int due;
        int idx;
        int prod;
    } rsp_t;

    rsp_t expQ[$];
    int   mPtr = 0;
    int   mCyc = 0;

    typedef struct {
        logic [NREQ-1:0]   valid;
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        logic [NREQ-1:0]   expReady;
        logic [SIZE-1:0]   expMulA;
        logic [SIZE-1:0]   expMulB;
        logic [NREQ-1:0]   expRspV;
        logic [2*SIZE-1:0] expRspD;
        logic              expBusy;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [W-1:0] a, input logic [W-1:0] b);
        reqValid = v;
        reqA     = a;
        reqB     = b;
    endtask

    // Reference model evaluated at the negedge: arbitration by rule, results from an ordered queue.
    task automatic modelEvaluate(input bit cmp);
        int              g;
        int              eA;
        int              eB;
        int              eD;
        bit              eBusy;
        logic [NREQ-1:0] eReady;
        logic [NREQ-1:0] eRspV;
        logic [W-1:0]    sa;
        logic [W-1:0]    sb;
        rsp_t            r;
        g      = -1;
        eA     = 0;
        eB     = 0;
        eD     = 0;
        eReady = '0;
        eRspV  = '0;
        if (!rstN) begin
            expQ.delete();
            mPtr = 0;
        end else begin
`ifdef MUL_ARB_RR_EN
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && reqValid[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
            end
`else
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && reqValid[k]) g = k;
            end
`endif
            if (expQ.size() > 0 && expQ[0].due == mCyc) begin
                r = expQ.pop_front();
                eRspV[r.idx] = 1'b1;
                eD = r.prod;
            end
            if (g >= 0) begin
                eReady[g] = 1'b1;
                sa = reqA >> (g * SIZE);
                sb = reqB >> (g * SIZE);
                eA = int'(sa[SIZE-1:0]);
                eB = int'(sb[SIZE-1:0]);
                expQ.push_back('{due: mCyc + MUL_LAT, idx: g, prod: eA * eB});
                mPtr = (g + 1) % NREQ;
            end
        end
        eBusy = (expQ.size() != 0);
        if (cmp) begin
            checkOutput($sformatf("model req_ready@%0d", mCyc), 32'(reqReady), 32'(eReady));
            checkOutput($sformatf("model mul_a@%0d", mCyc), 32'(mulA), eA);
            checkOutput($sformatf("model mul_b@%0d", mCyc), 32'(mulB), eB);
            checkOutput($sformatf("model rsp_valid@%0d", mCyc), 32'(rspValid), 32'(eRspV));
            checkOutput($sformatf("model rsp_data@%0d", mCyc), 32'(rspData), eD);
            checkOutput($sformatf("model busy@%0d", mCyc), 32'(busy), 32'(eBusy));
        end
        mCyc++;
    endtask

    task automatic endCycle(input bit cmp);
        modelEvaluate(cmp);
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle(input bit cmp);
        @(negedge clk);
        endCycle(cmp);
    endtask

    task automatic pulseReset();
        rstN = 1'b0;
        applyStimulus('0, '0, '0);
        runCycle(1'b1);
        rstN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{valid: 4'b0001, a: 16'hABC3, b: 16'hDEF5, expReady: 4'b0001, expMulA: 4'd3,  expMulB: 4'd5,  expRspV: 4'b0000, expRspD: 8'd0,   expBusy: 1'b1};
        vecs[1] = '{valid: 4'b0000, a: 16'hFFFF, b: 16'hFFFF, expReady: 4'b0000, expMulA: 4'd0,  expMulB: 4'd0,  expRspV: 4'b0000, expRspD: 8'd0,   expBusy: 1'b1};
        vecs[2] = '{valid: 4'b0000, a: 16'h0000, b: 16'h0000, expReady: 4'b0000, expMulA: 4'd0,  expMulB: 4'd0,  expRspV: 4'b0001, expRspD: 8'd15,  expBusy: 1'b0};
        vecs[3] = '{valid: 4'b0000, a: 16'h0000, b: 16'h0000, expReady: 4'b0000, expMulA: 4'd0,  expMulB: 4'd0,  expRspV: 4'b0000, expRspD: 8'd0,   expBusy: 1'b0};
        vecs[4] = '{valid: 4'b0100, a: 16'h5F3A, b: 16'hAF6C, expReady: 4'b0100, expMulA: 4'd15, expMulB: 4'd15, expRspV: 4'b0000, expRspD: 8'd0,   expBusy: 1'b1};
        vecs[5] = '{valid: 4'b0010, a: 16'hC707, b: 16'h3B94, expReady: 4'b0010, expMulA: 4'd0,  expMulB: 4'd9,  expRspV: 4'b0000, expRspD: 8'd0,   expBusy: 1'b1};
        vecs[6] = '{valid: 4'b0000, a: 16'h0000, b: 16'h0000, expReady: 4'b0000, expMulA: 4'd0,  expMulB: 4'd0,  expRspV: 4'b0100, expRspD: 8'd225, expBusy: 1'b1};
        vecs[7] = '{valid: 4'b0000, a: 16'h0000, b: 16'h0000, expReady: 4'b0000, expMulA: 4'd0,  expMulB: 4'd0,  expRspV: 4'b0010, expRspD: 8'd0,   expBusy: 1'b0};
        vecs[8] = '{valid: 4'b0000, a: 16'h0000, b: 16'h0000, expReady: 4'b0000, expMulA: 4'd0,  expMulB: 4'd0,  expRspV: 4'b0000, expRspD: 8'd0,   expBusy: 1'b0};

        // Reset held with every requester asking: all outputs must stay quiet.
        rstN = 1'b0;
        applyStimulus(4'hF, 16'h1234, 16'h5678);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) runCycle(1'b1);
        rstN = 1'b1;

        // Directed table; row 0 lands in the first cycle after reset release.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b);
            @(negedge clk);
            checkOutput($sformatf("vec%0d req_ready", i), 32'(reqReady), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d mul_a", i), 32'(mulA), 32'(vecs[i].expMulA));
            checkOutput($sformatf("vec%0d mul_b", i), 32'(mulB), 32'(vecs[i].expMulB));
            checkOutput($sformatf("vec%0d rsp_valid", i), 32'(rspValid), 32'(vecs[i].expRspV));
            checkOutput($sformatf("vec%0d rsp_data", i), 32'(rspData), 32'(vecs[i].expRspD));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
            endCycle(1'b0);
        end

        // All four requesting continuously with a=b=i+1.
        pulseReset();
        for (int k = 0; k < 8; k++) begin
            int rIdx;
            applyStimulus(4'hF, 16'h4321, 16'h4321);
            @(negedge clk);
`ifdef MUL_ARB_RR_EN
            checkOutput($sformatf("all4 grant k=%0d", k), 32'(reqReady), 32'(1) << (k % 4));
            rIdx = (k - 2) % 4;
`else
            checkOutput($sformatf("all4 grant k=%0d", k), 32'(reqReady), 32'(1));
            rIdx = 0;
`endif
            if (k >= 2) begin
                checkOutput($sformatf("all4 rsp_valid k=%0d", k), 32'(rspValid), 32'(1) << rIdx);
                checkOutput($sformatf("all4 rsp_data k=%0d", k), 32'(rspData), (rIdx + 1) * (rIdx + 1));
            end else begin
                checkOutput($sformatf("all4 rsp_valid k=%0d", k), 32'(rspValid), 32'(0));
            end
            endCycle(1'b1);
        end
        applyStimulus('0, '0, '0);
        for (int i = 0; i < 3; i++) runCycle(1'b1);

        // Reset one cycle after two grants: nothing may come back, pointer restarts at 0.
        applyStimulus(4'b0001, 16'h0002, 16'h0003);
        runCycle(1'b1);
        applyStimulus(4'b0010, 16'h0040, 16'h0050);
        runCycle(1'b1);
        rstN = 1'b0;
        applyStimulus(4'hF, 16'h9999, 16'h9999);
        @(negedge clk);
        checkOutput("midreset req_ready", 32'(reqReady), 32'(0));
        checkOutput("midreset mul_a", 32'(mulA), 32'(0));
        checkOutput("midreset rsp_valid", 32'(rspValid), 32'(0));
        checkOutput("midreset busy", 32'(busy), 32'(0));
        endCycle(1'b1);
        rstN = 1'b1;
        applyStimulus('0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("postreset rsp_valid %0d", i), 32'(rspValid), 32'(0));
            checkOutput($sformatf("postreset busy %0d", i), 32'(busy), 32'(0));
            endCycle(1'b1);
        end
        applyStimulus(4'hF, 16'h4321, 16'h4321);
        @(negedge clk);
        checkOutput("postreset first grant", 32'(reqReady), 32'(1));
        endCycle(1'b1);
        applyStimulus('0, '0, '0);
        for (int i = 0; i < 3; i++) runCycle(1'b1);

        // Requester 1 alone, with the pointer just past it: still granted immediately.
        applyStimulus(4'b0010, 16'h0070, 16'h0060);
        @(negedge clk);
        checkOutput("req1 first grant", 32'(reqReady), 32'(4'b0010));
        endCycle(1'b1);
        applyStimulus(4'b0010, 16'h0030, 16'h00D0);
        @(negedge clk);
        checkOutput("req1 pointer-last grant", 32'(reqReady), 32'(4'b0010));
        endCycle(1'b1);
        applyStimulus('0, '0, '0);
        for (int i = 0; i < 3; i++) runCycle(1'b1);

        // Randomized traffic with occasional single-cycle resets.
        for (int n = 0; n < 400; n++) begin
            rstN = ($urandom_range(0, 59) != 0);
            applyStimulus(NREQ'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            runCycle(1'b1);
        end
        rstN = 1'b1;
        applyStimulus('0, '0, '0);
        for (int i = 0; i < 4; i++) runCycle(1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 SHALL have parameter SIZE, default 4, meaning operand width in bits.
REQ-002 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have parameter MUL_LAT, default 2, meaning clock edges from operands presented to product valid on the shared multiplier.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-007 SHALL have port req_a  input  NREQ*SIZE  packed operand A; requester i at bits [i*SIZE +: SIZE].
REQ-008 SHALL have port req_b  input  NREQ*SIZE  packed operand B, same packing.
REQ-009 SHALL have port req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] && req_ready[i].
REQ-010 SHALL have port mul_a  output  SIZE  operand A to the shared multiplier.
REQ-011 SHALL have port mul_b  output  SIZE  operand B to the shared multiplier.
REQ-012 SHALL have port mul_res  input  2*SIZE  product from the shared multiplier.
REQ-013 SHALL have port rsp_valid  output  NREQ  one-hot result strobe, one cycle per accepted request.
REQ-014 SHALL have port rsp_data  output  2*SIZE  product for the requester flagged in rsp_valid.
REQ-015 SHALL have port busy  output  1  high while any accepted operation is in flight.

Function
REQ-016 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid and arbitration state; req_ready[i] only when req_valid[i].
REQ-017 SHALL drive mul_a/mul_b combinationally from the granted requester's operands in the grant cycle; all-zero when no grant.
REQ-018 SHALL accept a new request every cycle (full throughput); no request stalls beyond arbitration loss.
REQ-019 SHALL carry a tag (valid bit + requester index) through a MUL_LAT-deep shift register, advancing every cycle.
REQ-020 SHALL assert rsp_valid[i] combinationally from the tag leaving the pipe, in cycle t+MUL_LAT for a grant in cycle t, with rsp_data = mul_res in that cycle.
REQ-021 SHALL drive rsp_data to zero when no rsp_valid bit is set.
REQ-022 SHALL return results in grant order with no reordering and no loss; a requester's rsp_valid and a new grant to it in the same cycle are independent.
REQ-023 SHALL keep an in-flight counter (0..MUL_LAT): +1 on grant, -1 on response, unchanged on simultaneous grant and response; busy = (counter != 0).
REQ-024 SHALL accept no response-side backpressure; requesters consume rsp_valid in its cycle.
REQ-025 SHALL hold the round-robin pointer unchanged in cycles without a grant.

Reset
REQ-026 SHALL, while rst_n low, force req_ready=0, rsp_valid=0, rsp_data=0, mul_a=0, mul_b=0, busy=0, tag pipe cleared, counter=0, pointer=0.
REQ-027 SHALL discard every in-flight operation when reset asserts mid-operation; no rsp_valid for requests accepted before reset.
REQ-028 SHALL allow grants in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro MUL_ARB_RR_EN defined, arbitrate round-robin: search from pointer upward modulo NREQ; after grant to i, pointer = (i+1) mod NREQ.
REQ-030 SHALL, without MUL_ARB_RR_EN, use fixed priority (index 0 highest) and omit the pointer register.

Verification
REQ-031 SHALL cover: single req0 a=3,b=5 at cycle 10 -> req_ready[0]=1 cycle 10, rsp_valid=0001, rsp_data=15 at cycle 12, busy high cycles 10-11.
REQ-032 SHALL cover: all four requesting continuously, a=b=i+1, RR enabled -> grants 0,1,2,3,0,... one per cycle; rsp_data sequence 1,4,9,16,1 with matching rsp_valid.
REQ-033 SHALL cover: same as REQ-032 without MUL_ARB_RR_EN -> req0 granted every cycle, requesters 1-3 starve, rsp_data=1 each cycle.
REQ-034 SHALL cover: back-to-back req2 a=15,b=15 then req1 a=0,b=9 -> rsp 225 to requester 2 then 0 to requester 1 in consecutive cycles.
REQ-035 SHALL cover: rst_n pulsed low one cycle after two grants -> no rsp_valid afterwards, busy=0, next grant after release goes to requester 0.
REQ-036 SHALL cover: req1 only, with requester 1 pointer-last (RR) -> grant in same cycle, no idle-cycle penalty.
